saxi_rr_arbiter: RTL
====================

Name: saxi_rr_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit AXI-stream sink, such as a saxi passthru/processing block, between N_IN upstream sources.
- A grant is held for a burst of up to BURST beats, or until the granted source drops TVALID. Ownership then passes to the next requester in round-robin order.
- The output is a single registered stage, so downstream sees a standard AXI-stream master with the source index tagged on TID_OUT.

Parameters:
- N_IN, 4: number of input streams (2..8).
- DATA_W, 32: stream data width.
- BURST, 8: maximum beats per grant (1..256).
- IDX_W, $clog2(N_IN): width of source index. Derived; not overridden.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- TVALID_IN  in  N_IN  per-source valid.
- TREADY_IN  out  N_IN  per-source ready.
- TDATA_IN  in  N_IN*DATA_W  per-source data; source i occupies bits [i*DATA_W +: DATA_W].
- TVALID_OUT  out  1  output valid (registered).
- TREADY_OUT  in  1  downstream ready.
- TDATA_OUT  out  DATA_W  output data (registered).
- TID_OUT  out  IDX_W  index of the source of the current output beat (registered).
- GRANT_OUT  out  N_IN  one-hot current grant; all-zero in IDLE (registered, status only).

Behaviour:

Reset:
- ARESETn low clears asynchronously: TVALID_OUT=0, TDATA_OUT=0, TID_OUT=0, GRANT_OUT=0, state=IDLE, rr_ptr=0, beat_cnt=0.
- TREADY_IN is 0 throughout reset.
- A reset mid-burst discards the held output beat and the grant.

Output register:
- Define out_free = !TVALID_OUT || TREADY_OUT.
- On an input handshake: TDATA_OUT <= data of source g, TID_OUT <= g, TVALID_OUT <= 1.
- Else if TREADY_OUT: TVALID_OUT <= 0.
- Load and drain in the same cycle is legal and gives back-to-back beats at full rate.
- TDATA_OUT and TID_OUT hold their value while TVALID_OUT && !TREADY_OUT.

State IDLE:
- All TREADY_IN = 0.
- If any TVALID_IN is set, select g = the first index at or after rr_ptr with TVALID_IN set, searching modulo N_IN.
- On the next edge: state=GRANTED, GRANT_OUT=onehot(g), beat_cnt=0.
- If no source is valid, remain in IDLE.

State GRANTED (source g):
- TREADY_IN[g] = out_free. All other TREADY_IN bits = 0. TREADY_IN is combinational from state and out_free.
- On a handshake (TVALID_IN[g] && TREADY_IN[g]): beat_cnt++.
- Release when either condition holds:
  - a handshake occurs with beat_cnt == BURST-1, or
  - TVALID_IN[g] == 0 in any GRANTED cycle (idle owner yields).
- On release: state=IDLE, GRANT_OUT=0, rr_ptr=(g+1) mod N_IN, beat_cnt=0.

Timing:
- The grant change costs one IDLE bubble cycle.
- Data latency is 1 cycle from input handshake to TVALID_OUT.
- Sustained throughput per burst is 1 beat/cycle when TREADY_OUT=1. Aggregate throughput is BURST/(BURST+1).

Boundary conditions:
- BURST=1: release after every beat, giving strict beat-level round-robin.
- Only one requester present: it is re-granted after each bubble.
- rr_ptr wraps from N_IN-1 to 0.
- A source may drop TVALID only when not stalled; protocol compliance is the source's responsibility.
- If TVALID_IN[g] falls while TREADY_IN[g]=0, the cycle is treated as an idle owner and the grant is released.
- Sources never lose data: TREADY_IN is asserted only to the granted index.

Decomposition:
- Shared package saxi_pkg holds:
  - state enum {ST_IDLE, ST_GRANTED};
  - the default width constant SAXI_DATA_W=32;
  - a function rr_pick(req, ptr) returning the first set index at or after ptr, searching modulo N_IN.
- Natural sub-module: saxi_out_reg, the registered output stage (load/hold/drain plus out_free). It is reusable by other saxi blocks.
- The arbiter FSM stays in the top-level module.

Test Plan:
- Reset mid-burst: assert ARESETn=0 while GRANT_OUT=0010 and TVALID_OUT=1 -> all outputs 0 immediately (asynchronous). After release, the first grant goes to the lowest-index requester.
- All four sources valid continuously, TREADY_OUT=1, BURST=8 -> output sequence is 8 beats with TID 0, bubble, 8 beats TID 1, bubble, 8 beats TID 2, bubble, 8 beats TID 3, then wraps to TID 0. Data order is preserved per source.
- Source 2 alone sends 3 beats 0xA0..0xA2 then drops TVALID -> grant is released after the 3rd beat. rr_ptr=3. A next request from source 1 is granted in IDLE.
- Backpressure: TREADY_OUT held 0 for 5 cycles mid-burst -> TVALID_OUT stays 1, TDATA_OUT stable, TREADY_IN[g]=0. On release of the stall, beats resume with no loss or duplication and the beat count still ends at 8.
- BURST=1 with sources 0 and 3 always valid -> TID_OUT alternates 0,3,0,3 with one bubble between beats. TREADY_IN is never asserted to a non-granted source (checked by assertion).

Source files
------------

// File: rtl/saxi_pkg.sv
// Shared types and helpers for the saxi stream blocks.
// Holds the arbiter state encoding, the default data width and the round-robin pick.
package saxi_pkg;

    localparam int SAXI_DATA_W = 32;
    localparam int SAXI_MAX_N  = 8;

    typedef enum logic {
        ST_IDLE,
        ST_GRANTED
    } state_t;

    // First set bit of req at or after ptr, searching modulo n (n <= SAXI_MAX_N).
    // Returns ptr when req is empty; callers only use the result when |req.
    function automatic logic [2:0] rr_pick(
        input logic [7:0] req,
        input logic [2:0] ptr,
        input int         n
    );
        logic [2:0] pick;
        logic [3:0] idx;
        pick = ptr;
        // Walk from the farthest offset down so the nearest requester wins.
        for (int k = SAXI_MAX_N - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = {1'b0, ptr} + 4'(k);
                if (idx >= 4'(n)) begin
                    idx = idx - 4'(n);
                end
                if (req[idx[2:0]]) begin
                    pick = idx[2:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/saxi_rr_arbiter_if.sv
// Bundle of the arbiter's per-source inputs and its single tagged output stream.
// slave = arbiter side, master = the sources plus the downstream sink.
interface saxi_rr_arbiter_if
    import saxi_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int DATA_W = SAXI_DATA_W
);
    localparam int IDX_W = $clog2(N_IN);

    logic [N_IN-1:0]        TVALID_IN;
    logic [N_IN-1:0]        TREADY_IN;
    logic [N_IN*DATA_W-1:0] TDATA_IN;
    logic                   TVALID_OUT;
    logic                   TREADY_OUT;
    logic [DATA_W-1:0]      TDATA_OUT;
    logic [IDX_W-1:0]       TID_OUT;
    logic [N_IN-1:0]        GRANT_OUT;

    modport slave (
        input  TVALID_IN, TDATA_IN, TREADY_OUT,
        output TREADY_IN, TVALID_OUT, TDATA_OUT, TID_OUT, GRANT_OUT
    );

    modport master (
        output TVALID_IN, TDATA_IN, TREADY_OUT,
        input  TREADY_IN, TVALID_OUT, TDATA_OUT, TID_OUT, GRANT_OUT
    );

endinterface

// File: rtl/saxi_out_reg.sv
// Registered AXI-stream output stage with source tag: load, hold or drain.
// Latency: one cycle from ld_vld to out_vld.
// Backpressure: holds data/tag while out_vld && !dn_rdy; out_free tells the producer when a load is safe.
module saxi_out_reg
    import saxi_pkg::*;
#(
    parameter int DATA_W = SAXI_DATA_W,
    parameter int IDX_W  = 2
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              ld_vld,
    input  logic [DATA_W-1:0] ld_dat,
    input  logic [IDX_W-1:0]  ld_id,
    input  logic              dn_rdy,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_dat,
    output logic [IDX_W-1:0]  out_id,
    output logic              out_free
);

    assign out_free = !out_vld || dn_rdy;

    // A load while draining gives full-rate back-to-back beats.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            out_vld <= 1'b0;
            out_dat <= '0;
            out_id  <= '0;
        end else if (ld_vld) begin
            out_vld <= 1'b1;
            out_dat <= ld_dat;
            out_id  <= ld_id;
        end else if (dn_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/saxi_rr_arbiter.sv
// Round-robin arbiter sharing one AXI-stream sink among N_IN sources, bursts of up to BURST beats.
// Latency: one cycle input handshake to TVALID_OUT; one IDLE bubble per grant change.
// Backpressure: only the granted source sees TREADY_IN, and only while the output register is free.
module saxi_rr_arbiter
    import saxi_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int DATA_W = SAXI_DATA_W,
    parameter int BURST  = 8
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    saxi_rr_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(N_IN);
    localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_IN - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [N_IN-1:0]   grant_q, grant_d;

    logic [IDX_W-1:0]  pick;
    logic [N_IN-1:0]   tready;
    logic              owner_vld;
    logic              in_hs;
    logic              out_free;

    assign pick = IDX_W'(rr_pick(8'(bus.TVALID_IN), 3'(rr_ptr_q), N_IN));

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= ST_IDLE;
            gnt_idx_q  <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            grant_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            grant_q    <= grant_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        grant_d    = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.TVALID_IN) begin
                    state_d    = ST_GRANTED;
                    gnt_idx_d  = pick;
                    grant_d    = N_IN'(1) << pick;
                    beat_cnt_d = '0;
                end
            end
            ST_GRANTED: begin
                // An owner that drops valid yields even if it was stalled.
                if (!owner_vld || (in_hs && beat_cnt_q == LAST_BEAT)) begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    beat_cnt_d = '0;
                    rr_ptr_d   = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + IDX_W'(1);
                end else if (in_hs) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        tready    = '0;
        owner_vld = bus.TVALID_IN[gnt_idx_q];
        in_hs     = 1'b0;
        if (state_q == ST_GRANTED) begin
            tready[gnt_idx_q] = out_free;
            in_hs             = owner_vld && out_free;
        end
    end

    assign bus.TREADY_IN = tready;
    assign bus.GRANT_OUT = grant_q;

    saxi_out_reg #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_out_reg (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .ld_vld   (in_hs),
        .ld_dat   (bus.TDATA_IN[gnt_idx_q*DATA_W +: DATA_W]),
        .ld_id    (gnt_idx_q),
        .dn_rdy   (bus.TREADY_OUT),
        .out_vld  (bus.TVALID_OUT),
        .out_dat  (bus.TDATA_OUT),
        .out_id   (bus.TID_OUT),
        .out_free (out_free)
    );

endmodule
